// File: rtl/cacheline_adapter_if.sv
// Bundles the cache-side line port (dfp) and the burst-memory beat port (bmem).
// The master modport is the adapter's view; the slave modport is the cache and memory around it.
interface cacheline_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);

  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

endinterface

// File: rtl/cacheline_adapter.sv
// Splits line reads/writes from the cache into 4-beat bursts on the burst memory
// and reassembles returning read beats into a full line. One transaction at a time.
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cacheline_adapter_if.master  bus
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] OFFSET_MASK = 32'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    DONE
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [CNT_W-1:0]             beat_cnt;
  logic [31:0]                  addr_q;
  logic [BEATS-1:0][BEAT_W-1:0] line_buf;
  logic [BEATS-1:0][BEAT_W-1:0] line_merged;
  logic [LINE_W-1:0]            rdata_q;
  logic [31:0]                  line_addr;
  logic                         beat_hit;
  logic                         last_beat;

  assign line_addr = bus.dfp_addr & ~OFFSET_MASK;
  assign beat_hit  = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
  assign last_beat = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.dfp_write) begin
          state_next = WR_BURST;
        end else if (bus.dfp_read) begin
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bus.bmem_ready) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (beat_hit && last_beat) begin
          state_next = DONE;
        end
      end
      WR_BURST: begin
        if (bus.bmem_ready && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from state and registered data only, so an async
  // reset clears them at once and no dfp input leaks through combinationally.
  always_comb begin
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_addr  = '0;
    bus.bmem_wdata = '0;
    bus.dfp_resp   = 1'b0;
    case (state)
      RD_REQ: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = addr_q;
      end
      WR_BURST: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = addr_q;
        bus.bmem_wdata = line_buf[beat_cnt];
      end
      DONE: begin
        bus.dfp_resp = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.dfp_rdata = rdata_q;

  always_comb begin
    line_merged           = line_buf;
    line_merged[beat_cnt] = bus.bmem_rdata;
  end

  // line_buf holds write data during a write and collects beats during a read;
  // rdata_q is only replaced when a read completes so dfp_rdata stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      addr_q   <= '0;
      line_buf <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (bus.dfp_write) begin
            addr_q   <= line_addr;
            line_buf <= bus.dfp_wdata;
          end else if (bus.dfp_read) begin
            addr_q <= line_addr;
          end
        end
        RD_WAIT: begin
          if (beat_hit) begin
            line_buf[beat_cnt] <= bus.bmem_rdata;
            beat_cnt           <= beat_cnt + CNT_W'(1);
            if (last_beat) begin
              rdata_q <= line_merged;
            end
          end
        end
        WR_BURST: begin
          if (bus.bmem_ready) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: a transaction-level model predicts every
// output each cycle, and literal checks pin latencies, beat order and assembled lines.
module tb_cacheline_adapter;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  cacheline_adapter_if #(.LINE_W(256), .BEAT_W(64)) bus ();

  cacheline_adapter #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: a pending line transfer, beats moved so far, and the last read line.
  logic         m_busy     = 1'b0;
  logic         m_is_write = 1'b0;
  logic         m_accepted = 1'b0;
  logic         m_resp     = 1'b0;
  int           m_beats    = 0;
  logic [31:0]  m_addr     = '0;
  logic [255:0] m_line     = '0;
  logic [255:0] m_rdline   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_is_write <= 1'b0; m_accepted <= 1'b0; m_resp <= 1'b0;
      m_beats <= 0; m_addr <= '0; m_line <= '0; m_rdline <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (!m_busy) begin
      if (bus.dfp_write || bus.dfp_read) begin
        m_busy     <= 1'b1;
        m_is_write <= bus.dfp_write;
        m_accepted <= 1'b0;
        m_beats    <= 0;
        m_addr     <= bus.dfp_addr & 32'hFFFF_FFE0;
        m_line     <= bus.dfp_write ? bus.dfp_wdata : 256'd0;
      end
    end else if (m_is_write) begin
      if (bus.bmem_ready) begin
        m_beats <= m_beats + 1;
        if (m_beats == 3) begin
          m_busy <= 1'b0;
          m_resp <= 1'b1;
        end
      end
    end else if (!m_accepted) begin
      if (bus.bmem_ready) m_accepted <= 1'b1;
    end else if (bus.bmem_rvalid && bus.bmem_raddr == m_addr) begin
      m_line[m_beats*64 +: 64] <= bus.bmem_rdata;
      m_beats <= m_beats + 1;
      if (m_beats == 3) begin
        m_busy   <= 1'b0;
        m_resp   <= 1'b1;
        m_rdline <= {bus.bmem_rdata, m_line[191:0]};
      end
    end
  end

  // Observations kept cumulatively; each test measures deltas from its own start.
  int           resp_cnt  = 0;
  int           wr_cycles = 0;
  int           rd_cycles = 0;
  int           resp_cyc  = 0;
  logic [255:0] resp_rdata = '0;
  logic [63:0]  acc_q[$];
  logic [63:0]  wr_seen[$];
  logic [31:0]  addr_seen[$];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("dfp_resp", 256'(bus.dfp_resp), 256'(m_resp));
      checkOutput("bmem_read", 256'(bus.bmem_read), 256'(m_busy && !m_is_write && !m_accepted));
      checkOutput("bmem_write", 256'(bus.bmem_write), 256'(m_busy && m_is_write));
      if (m_busy && (m_is_write || !m_accepted))
        checkOutput("bmem_addr", 256'(bus.bmem_addr), 256'(m_addr));
      if (m_busy && m_is_write)
        checkOutput("bmem_wdata", 256'(bus.bmem_wdata), 256'(m_line[m_beats*64 +: 64]));
      checkOutput("dfp_rdata", bus.dfp_rdata, m_rdline);
      if (bus.bmem_write) begin
        wr_cycles++;
        wr_seen.push_back(bus.bmem_wdata);
        if (bus.bmem_ready) acc_q.push_back(bus.bmem_wdata);
      end
      if (bus.bmem_read) rd_cycles++;
      if (bus.bmem_read || bus.bmem_write) addr_seen.push_back(bus.bmem_addr);
      if (bus.dfp_resp) begin
        resp_cnt++;
        resp_cyc   = cyc;
        resp_rdata = bus.dfp_rdata;
      end
    end
  end

  function automatic logic [255:0] packBeats(input int base);
    logic [255:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (base + i < acc_q.size()) r[i*64 +: 64] = acc_q[base + i];
    return r;
  endfunction

  function automatic int countValue(input int base, input logic [63:0] value);
    int n = 0;
    for (int i = base; i < wr_seen.size(); i++)
      if (wr_seen[i] == value) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [255:0] wdata);
    bus.dfp_read  = rd;
    bus.dfp_write = wr;
    bus.dfp_addr  = addr;
    bus.dfp_wdata = wdata;
  endtask

  task automatic waitResp(input int max_cycles);
    bit got = 0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk);
      if (bus.dfp_resp) got = 1;
    end
    if (!got) checkOutput("resp_timeout", 256'(0), 256'(1));
    tick();
    bus.dfp_read  = 1'b0;
    bus.dfp_write = 1'b0;
  endtask

  task automatic driveBeat(input logic [31:0] raddr, input logic [63:0] data);
    bus.bmem_rvalid = 1'b1;
    bus.bmem_raddr  = raddr;
    bus.bmem_rdata  = data;
    tick();
    bus.bmem_rvalid = 1'b0;
    bus.bmem_raddr  = '0;
    bus.bmem_rdata  = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int c0, last_cyc, r0, w0, d0, a0, s0, x0;

    rst_n = 1'b0;
    bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_addr = '0; bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b1; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    tick();
    tick();
    checkOutput("rst_resp", 256'(bus.dfp_resp), 256'(0));
    checkOutput("rst_read", 256'(bus.bmem_read), 256'(0));
    checkOutput("rst_write", 256'(bus.bmem_write), 256'(0));
    checkOutput("rst_addr", 256'(bus.bmem_addr), 256'(0));
    checkOutput("rst_wdata", 256'(bus.bmem_wdata), 256'(0));
    checkOutput("rst_rdata", bus.dfp_rdata, 256'(0));
    rst_n = 1'b1;
    tick();

    // Write, ready always high
    r0 = resp_cnt; w0 = wr_cycles; a0 = acc_q.size(); s0 = addr_seen.size();
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 32'h1000_0024, {64'hD, 64'hC, 64'hB, 64'hA});
    waitResp(40);
    tick(); tick();
    checkOutput("wr1_beats", packBeats(a0), {64'hD, 64'hC, 64'hB, 64'hA});
    checkOutput("wr1_accepted", 256'(acc_q.size() - a0), 256'(4));
    checkOutput("wr1_write_cycles", 256'(wr_cycles - w0), 256'(4));
    checkOutput("wr1_addr", 256'((addr_seen.size() > s0) ? addr_seen[s0] : 32'hFFFF_FFFF),
                256'(32'h1000_0020));
    checkOutput("wr1_resp_count", 256'(resp_cnt - r0), 256'(1));
    checkOutput("wr1_resp_latency", 256'(resp_cyc - c0), 256'(5));

    // Write with ready low for 3 cycles on beat 1
    r0 = resp_cnt; w0 = wr_cycles; a0 = acc_q.size(); x0 = wr_seen.size();
    applyStimulus(1'b0, 1'b1, 32'h2000_0040,
                  {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                   64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001});
    tick();
    tick();
    bus.bmem_ready = 1'b0;
    tick(); tick(); tick();
    bus.bmem_ready = 1'b1;
    waitResp(40);
    tick(); tick();
    checkOutput("wr2_beats", packBeats(a0),
                {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001});
    checkOutput("wr2_accepted", 256'(acc_q.size() - a0), 256'(4));
    checkOutput("wr2_write_cycles", 256'(wr_cycles - w0), 256'(7));
    checkOutput("wr2_beat1_held", 256'(countValue(x0, 64'hCAFE_0000_0000_0002)), 256'(4));
    checkOutput("wr2_resp_count", 256'(resp_cnt - r0), 256'(1));

    // Read with 2-cycle gaps between beats
    r0 = resp_cnt; d0 = rd_cycles;
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, '0);
    for (int i = 0; i < 4; i++) begin
      tick(); tick();
      last_cyc = cyc;
      driveBeat(32'h0000_0040, 64'h11 * 64'(i + 1));
    end
    waitResp(40);
    tick(); tick();
    checkOutput("rd1_line", resp_rdata, {64'h44, 64'h33, 64'h22, 64'h11});
    checkOutput("rd1_resp_count", 256'(resp_cnt - r0), 256'(1));
    checkOutput("rd1_resp_latency", 256'(resp_cyc - last_cyc), 256'(1));
    checkOutput("rd1_read_cycles", 256'(rd_cycles - d0), 256'(1));

    // Read with ready stalled 2 cycles and a stray beat tagged 0x80
    r0 = resp_cnt; d0 = rd_cycles;
    bus.bmem_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0000_005C, '0);
    tick(); tick(); tick();
    bus.bmem_ready = 1'b1;
    tick();
    driveBeat(32'h0000_0040, 64'h55);
    driveBeat(32'h0000_0040, 64'h66);
    driveBeat(32'h0000_0080, 64'hDEAD);
    driveBeat(32'h0000_0040, 64'h77);
    last_cyc = cyc;
    driveBeat(32'h0000_0040, 64'h88);
    waitResp(40);
    tick(); tick();
    checkOutput("rd2_line", resp_rdata, {64'h88, 64'h77, 64'h66, 64'h55});
    checkOutput("rd2_resp_count", 256'(resp_cnt - r0), 256'(1));
    checkOutput("rd2_resp_latency", 256'(resp_cyc - last_cyc), 256'(1));
    checkOutput("rd2_read_cycles", 256'(rd_cycles - d0), 256'(3));

    // Read and write together: the write wins
    r0 = resp_cnt; d0 = rd_cycles; a0 = acc_q.size();
    applyStimulus(1'b1, 1'b1, 32'h0000_0300,
                  {64'hBEEF_0004, 64'hBEEF_0003, 64'hBEEF_0002, 64'hBEEF_0001});
    waitResp(40);
    tick(); tick();
    checkOutput("both_beats", packBeats(a0),
                {64'hBEEF_0004, 64'hBEEF_0003, 64'hBEEF_0002, 64'hBEEF_0001});
    checkOutput("both_no_read", 256'(rd_cycles - d0), 256'(0));
    checkOutput("both_resp_count", 256'(resp_cnt - r0), 256'(1));
    checkOutput("both_rdata_kept", bus.dfp_rdata, {64'h88, 64'h77, 64'h66, 64'h55});

    // Reset asserted between clock edges during beat 2 of a write
    applyStimulus(1'b0, 1'b1, 32'h0000_0500, {64'h4, 64'h3, 64'h2, 64'h1});
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_resp", 256'(bus.dfp_resp), 256'(0));
    checkOutput("mid_rst_read", 256'(bus.bmem_read), 256'(0));
    checkOutput("mid_rst_write", 256'(bus.bmem_write), 256'(0));
    checkOutput("mid_rst_addr", 256'(bus.bmem_addr), 256'(0));
    checkOutput("mid_rst_wdata", 256'(bus.bmem_wdata), 256'(0));
    checkOutput("mid_rst_rdata", bus.dfp_rdata, 256'(0));
    applyStimulus(1'b0, 1'b0, '0, '0);
    r0 = resp_cnt; w0 = wr_cycles;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) tick();
    checkOutput("post_rst_no_resp", 256'(resp_cnt - r0), 256'(0));
    checkOutput("post_rst_no_write", 256'(wr_cycles - w0), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
